// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter for the four execution units
// (0 ALU, 1 MUL, 2 DIV, 3 LD/ST). Each unit owns a one-entry holding
// buffer; a round-robin arbiter broadcasts one buffered result per cycle
// on the registered CDB. issueblk_done tells the issue queue when the
// unit's buffer can take its next result.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_valid,
  input  logic [4*TAG_W-1:0]  req_tag,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          issueblk_done,
  output logic                CDB_valid,
  output logic [TAG_W-1:0]    CDB_tag,
  output logic [DATA_W-1:0]   CDB_data,
  output logic [1:0]          CDB_src
);

  localparam int N = 4;

  logic [N-1:0]      full;
  logic [1:0]        rr_ptr;
  logic [TAG_W-1:0]  buf_tag  [N];
  logic [DATA_W-1:0] buf_data [N];

  logic [N-1:0]      gnt;
  logic [1:0]        gnt_idx;
  logic [N-1:0]      accept;

  // Round-robin grant: first full buffer found scanning up from rr_ptr.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    // NOTE: every variable gets a default before the loop so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    gnt     = '0;
    gnt_idx = rr_ptr;
    found   = 1'b0;
    idx     = rr_ptr;
    for (int k = 0; k < N; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && full[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  // A unit may deliver when its buffer is empty or is draining this cycle.
  assign issueblk_done = ~full | gnt;
  assign accept        = req_valid & issueblk_done;

  // Occupancy, pointer and CDB output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      rr_ptr    <= '0;
      CDB_valid <= 1'b0;
      CDB_tag   <= '0;
      CDB_data  <= '0;
      CDB_src   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge state, so drain and refill of one buffer do not race.
      for (int i = 0; i < N; i++) begin
        if (accept[i])   full[i] <= 1'b1;
        else if (gnt[i]) full[i] <= 1'b0;
      end
      CDB_valid <= |gnt;
      if (|gnt) begin
        rr_ptr   <= gnt_idx + 2'd1;
        CDB_tag  <= buf_tag[gnt_idx];
        CDB_data <= buf_data[gnt_idx];
        CDB_src  <= gnt_idx;
      end
    end
  end

  // Result capture into the holding buffers.
  // NOTE: the buffer storage has no reset; full[] qualifies its contents,
  // so only the occupancy bits need clearing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i] && rst_n) begin
        buf_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
        buf_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts
// every broadcast and the per-unit ready; a monitor compares the CDB.
module tb_cdb_arbiter;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  typedef struct packed {
    logic [1:0]        src;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bcast_t;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          req_valid;
  logic [4*TAG_W-1:0]  req_tag;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          issueblk_done;
  logic                CDB_valid;
  logic [TAG_W-1:0]    CDB_tag;
  logic [DATA_W-1:0]   CDB_data;
  logic [1:0]          CDB_src;

  logic [TAG_W-1:0]    tag_in  [4];
  logic [DATA_W-1:0]   data_in [4];

  always #5 clk = ~clk;

  always_comb begin
    req_tag  = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*TAG_W +: TAG_W]    = tag_in[i];
      req_data[i*DATA_W +: DATA_W] = data_in[i];
    end
  end

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .issueblk_done(issueblk_done), .CDB_valid(CDB_valid),
    .CDB_tag(CDB_tag), .CDB_data(CDB_data), .CDB_src(CDB_src)
  );

  int n_pass   = 0;
  int n_checks = 0;

  bcast_t exp_q [$];      // broadcasts expected on the CDB, oldest first
  bcast_t unit_q [4][$];  // results each unit has handed over, not yet broadcast
  int     m_ptr;          // unit with top priority next
  bit     pend [4];       // unit is presenting a result not yet accepted

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every cycle out of reset, the CDB must match the scoreboard head.
  initial begin
    bcast_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cdb_valid", 64'(CDB_valid), 64'd1);
          check("cdb_src",   64'(CDB_src),   64'(e.src));
          check("cdb_tag",   64'(CDB_tag),   64'(e.tag));
          check("cdb_data",  64'(CDB_data),  64'(e.data));
        end else begin
          check("cdb_idle", 64'(CDB_valid), 64'd0);
        end
      end
    end
  end

  // One clock cycle: predict winner and ready, then apply the edge to the model.
  task automatic cycle(output logic [3:0] acc);
    int         win;
    logic [3:0] rdy;
    bcast_t     r;
    win = -1;
    for (int k = 0; k < 4; k++) begin
      int u;
      u = (m_ptr + k) % 4;
      if (win < 0 && unit_q[u].size() > 0) win = u;
    end
    for (int i = 0; i < 4; i++) rdy[i] = (unit_q[i].size() == 0) || (win == i);
    check("issueblk_done", 64'(issueblk_done), 64'(rdy));
    @(posedge clk);
    if (win >= 0) begin
      exp_q.push_back(unit_q[win].pop_front());
      m_ptr = (win + 1) % 4;
    end
    acc = req_valid & rdy;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        r.src  = 2'(i);
        r.tag  = tag_in[i];
        r.data = data_in[i];
        unit_q[i].push_back(r);
      end
    end
    #1;
  endtask

  task automatic put(input int u, input int t, input logic [DATA_W-1:0] d);
    pend[u]    = 1'b1;
    tag_in[u]  = TAG_W'(t);
    data_in[u] = d;
  endtask

  // Units start new results with probability pct%, holding each until accepted.
  task automatic run(input int ncyc, input int pct);
    logic [3:0] acc;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(99) < pct)
          put(i, int'($urandom_range(63)), DATA_W'($urandom));
        req_valid[i] = pend[i];
      end
      cycle(acc);
      for (int i = 0; i < 4; i++) if (acc[i]) pend[i] = 1'b0;
    end
  endtask

  task automatic feed(input int u, input int t);
    put(u, t, DATA_W'($urandom));
    for (int k = 0; k < 8 && pend[u]; k++) run(1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(CDB_valid), 64'd0);
    check({tag, "_tag"},   64'(CDB_tag),   64'd0);
    check({tag, "_data"},  64'(CDB_data),  64'd0);
    check({tag, "_src"},   64'(CDB_src),   64'd0);
    check({tag, "_done"},  64'(issueblk_done), 64'hF);
  endtask

  // Asynchronous reset between edges, requests held during reset, clean release.
  task automatic mid_reset();
    req_valid = '0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      unit_q[i].delete();
      pend[i] = 1'b0;
    end
    m_ptr = 0;
    req_valid = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1 check("rst_hold_done", 64'(issueblk_done), 64'hF);
    req_valid = '0;
    #1 rst_n = 1'b1;
    #1 check("rst_release_done",  64'(issueblk_done), 64'hF);
    check("rst_release_valid", 64'(CDB_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = '0;
    m_ptr     = 0;
    for (int i = 0; i < 4; i++) begin
      tag_in[i]  = '0;
      data_in[i] = '0;
      pend[i]    = 1'b0;
    end
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2, 0);

    // Four-way contention from rr_ptr = 0: tags 1..4 in unit order.
    for (int i = 0; i < 4; i++) put(i, i + 1, DATA_W'(32'h100 + i));
    run(8, 0);

    // Single uncontended ALU result.
    put(0, 'h05, 32'h1234);
    run(5, 0);

    // MUL and DIV requesting continuously.
    for (int c = 0; c < 12; c++) begin
      if (!pend[1]) put(1, int'($urandom_range(63)), DATA_W'($urandom));
      if (!pend[2]) put(2, int'($urandom_range(63)), DATA_W'($urandom));
      run(1, 0);
    end
    run(6, 0);

    // LD/ST back-to-back through drain/refill.
    feed(3, 'h09);
    feed(3, 'h0A);
    feed(3, 'h0B);
    run(6, 0);

    // DIV full and losing arbitration while it holds tag 0x20.
    put(0, 'h11, DATA_W'($urandom));
    put(1, 'h12, DATA_W'($urandom));
    put(2, 'h1F, DATA_W'($urandom));
    run(1, 0);
    put(0, 'h13, DATA_W'($urandom));
    put(1, 'h14, DATA_W'($urandom));
    put(2, 'h20, DATA_W'($urandom));
    run(10, 0);

    // All four buffers full, then asynchronous reset.
    for (int i = 0; i < 4; i++) put(i, 'h30 + i, DATA_W'($urandom));
    run(1, 0);
    for (int i = 0; i < 4; i++) put(i, 'h38 + i, DATA_W'($urandom));
    run(1, 0);
    mid_reset();
    run(4, 0);

    // Randomized traffic at several loads, then drain.
    run(300, 25);
    run(300, 70);
    run(200, 100);
    run(20, 0);

    @(negedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("model_empty", 64'(unit_q[0].size() + unit_q[1].size() +
                             unit_q[2].size() + unit_q[3].size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
